debouncer_n: RTL and testbench



---
 rtl/debouncer_n_pkg.sv | 9 +
 rtl/debounce_channel.sv | 57 +++++
 rtl/debouncer_n.sv | 61 ++++++
 tb/tb_debouncer_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_n_pkg.sv
// debouncer_n_pkg: shared helpers for the debouncer_n input conditioner
package debouncer_n_pkg;

   // Strobe pair {rise, fall} for an output that has just taken the value newLevel.
   function automatic logic [1:0] edgeStrobes(input logic newLevel);
      return {newLevel, ~newLevel};
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronised, debounced input with rise/fall strobes
//   clk     in   system clock
//   resetN  in   asynchronous active-low reset
//   tick    in   count enable from the shared prescaler
//   in      in   raw asynchronous input
//   out     out  debounced level
//   rise    out  one-cycle pulse on out 0->1
//   fall    out  one-cycle pulse on out 1->0
module debounce_channel
   import debouncer_n_pkg::*;
#(
   parameter int   COUNTER_BITS = 5,
   parameter int   SYNC_STAGES  = 2,
   parameter logic RESET_VALUE  = 1'b1
) (
   input  logic clk,
   input  logic resetN,
   input  logic tick,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
);
   localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0]  syncQ;
   logic [COUNTER_BITS-1:0] cnt;
   logic                    s;

   assign s = syncQ[SYNC_STAGES-1];

   // Any cycle where the synchronised input agrees with out throws away progress,
   // tick or not; only ticks seen while mismatched advance the count.
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         syncQ <= {SYNC_STAGES{RESET_VALUE}};
         cnt   <= '0;
         out   <= RESET_VALUE;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         syncQ        <= {syncQ[SYNC_STAGES-2:0], in};
         {rise, fall} <= 2'b00;
         if (s == out)
            cnt <= '0;
         else if (tick) begin
            if (cnt != CNT_MAX)
               cnt <= cnt + COUNTER_BITS'(1);
            else begin
               out          <= s;
               cnt          <= '0;
               {rise, fall} <= edgeStrobes(s);
            end
         end
      end

endmodule

// File: rtl/debouncer_n.sv
// debouncer_n: multi-channel synchroniser/debouncer with shared prescaler
//   clk     in   system clock
//   resetN  in   asynchronous active-low reset
//   in      in   [CHANNELS] raw asynchronous inputs
//   out     out  [CHANNELS] debounced levels
//   rise    out  [CHANNELS] one-cycle pulse when out[i] goes 0->1
//   fall    out  [CHANNELS] one-cycle pulse when out[i] goes 1->0
module debouncer_n
   import debouncer_n_pkg::*;
#(
   parameter int                  CHANNELS      = 2,
   parameter int                  COUNTER_BITS  = 5,
   parameter int                  SYNC_STAGES   = 2,
   parameter int                  PRESCALE_BITS = 0,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = '1
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);
   logic tick;

   generate
      if (PRESCALE_BITS == 0) begin : gNoPre
         assign tick = 1'b1;
      end else begin : gPre
         logic [PRESCALE_BITS-1:0] preCnt;
         logic                     tickQ;
         // Registered so the tick is glitch-free: one cycle in every 2^PRESCALE_BITS.
         always_ff @(posedge clk or negedge resetN)
            if (!resetN) begin
               preCnt <= '0;
               tickQ  <= 1'b0;
            end else begin
               preCnt <= preCnt + PRESCALE_BITS'(1);
               tickQ  <= &preCnt;
            end
         assign tick = tickQ;
      end
   endgenerate

   for (genvar g = 0; g < CHANNELS; g++) begin : gCh
      debounce_channel #(
         .COUNTER_BITS(COUNTER_BITS),
         .SYNC_STAGES (SYNC_STAGES),
         .RESET_VALUE (RESET_VALUE[g])
      ) uCh (
         .clk   (clk),
         .resetN(resetN),
         .tick  (tick),
         .in    (in[g]),
         .out   (out[g]),
         .rise  (rise[g]),
         .fall  (fall[g])
      );
   end

endmodule

// File: tb/tb_debouncer_n.sv
// tb_debouncer_n: self-checking bench for debouncer_n
module tb_debouncer_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetN = 1'b0;
   logic [3:0] inA = 4'h0;
   logic [3:0] outA, riseA, fallA;
   logic [1:0] outC, riseC, fallC;
   logic       inB = 1'b1;
   logic       outB, riseB, fallB;

   int checks = 0, failures = 0;

   debouncer_n #(.CHANNELS(4), .COUNTER_BITS(4), .SYNC_STAGES(2), .PRESCALE_BITS(0), .RESET_VALUE(4'b1111))
      dutA (.clk(clk), .resetN(resetN), .in(inA), .out(outA), .rise(riseA), .fall(fallA));
   debouncer_n #(.CHANNELS(1), .COUNTER_BITS(2), .SYNC_STAGES(2), .PRESCALE_BITS(3), .RESET_VALUE(1'b1))
      dutB (.clk(clk), .resetN(resetN), .in(inB), .out(outB), .rise(riseB), .fall(fallB));
   debouncer_n dutC (.clk(clk), .resetN(resetN), .in(inA[1:0]), .out(outC), .rise(riseC), .fall(fallC));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model of dutA: a channel flips once its synchronised input (the raw input two
   // edges late, reset value before that) has disagreed with out on 16 consecutive
   // edges, all after that channel's previous flip.
   localparam int WIN = 16;
   logic [3:0] inHist [0:8191];
   logic [3:0] outM = 4'hF, riseM = 4'h0, fallM = 4'h0;
   int         k = 0;
   int         lastFlip [4] = '{0, 0, 0, 0};

   always @(posedge clk) begin
      logic       flip;
      logic [3:0] sv;
      if (!resetN) begin
         k = 0;
         outM = 4'hF; riseM = 4'h0; fallM = 4'h0;
         for (int i = 0; i < 4; i++) lastFlip[i] = 0;
      end else begin
         k++;
         inHist[k] = inA;
         riseM = 4'h0; fallM = 4'h0;
         for (int i = 0; i < 4; i++) begin
            flip = (k - WIN + 1) > lastFlip[i];
            for (int j = k - WIN + 1; j <= k && flip; j++) begin
               sv = (j > 2) ? inHist[j-2] : 4'hF;
               if (sv[i] == outM[i]) flip = 1'b0;
            end
            if (flip) begin
               outM[i] = ~outM[i];
               riseM[i] = outM[i];
               fallM[i] = ~outM[i];
               lastFlip[i] = k;
            end
         end
      end
   end

   always @(negedge clk)
      if (!resetN) check("resetA", {outA, riseA, fallA}, {4'hF, 8'h00});
      else         check("modelA", {outA, riseA, fallA}, {outM, riseM, fallM});

   int fall0Cnt = 0, strobeCnt = 0, fallBCnt = 0;
   always @(negedge clk) begin
      fall0Cnt  += int'(fallA[0]);
      strobeCnt += $countones(riseA | fallA);
      fallBCnt  += int'(fallB);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitA(input int ch, input logic val, input int limit,
                        output int n, output logic [3:0] r, output logic [3:0] f);
      n = -1; r = 4'h0; f = 4'h0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (outA[ch] == val) begin n = c; r = riseA; f = fallA; break; end
      end
   endtask

   task automatic waitB(input logic val, input int limit, output int n, output logic f);
      n = -1; f = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (outB == val) begin n = c; f = fallB; break; end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nA, nC, base;
      logic [3:0] r, f, fA;
      logic [1:0] fC;
      logic fb;
      cycles(3);
      #1;
      check("rstOutA", outA, 4'hF);
      check("rstStrobeA", {riseA, fallA}, 8'h00);
      check("rstOutC", {outC, riseC, fallC}, 6'b110000);
      check("rstOutB", {outB, riseB, fallB}, 3'b100);
      @(negedge clk);
      resetN = 1'b1;
      nA = 0; nC = 0; fA = 4'h0; fC = 2'b00;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (outA == 4'h0 && nA == 0) begin nA = c; fA = fallA; end
         if (outC == 2'b00 && nC == 0) begin nC = c; fC = fallC; end
      end
      check("relEdgeA", nA, 18);
      check("relFallA", fA, 4'hF);
      check("relEdgeC", nC, 34);
      check("relFallC", fC, 2'b11);
      // clean step on channel 0
      inA = 4'hF;
      waitA(0, 1'b1, 40, n, r, f);
      check("stepSetup", n, 18);
      cycles(3);
      inA[0] = 1'b0;
      waitA(0, 1'b0, 40, n, r, f);
      check("stepEdge", n, 18);
      check("stepFall", f, 4'b0001);
      check("stepOthers", outA[3:1], 3'b111);
      // bounce restarts the count
      inA[0] = 1'b1;
      waitA(0, 1'b1, 40, n, r, f);
      check("bounceSetupRise", r, 4'b0001);
      cycles(3);
      #1 base = fall0Cnt;
      inA[0] = 1'b0;
      cycles(10);
      inA[0] = 1'b1;
      cycles(2);
      inA[0] = 1'b0;
      waitA(0, 1'b0, 40, n, r, f);
      check("bounceEdge", n, 18);
      cycles(2);
      #1 check("bounceOneFall", fall0Cnt - base, 1);
      // 15-cycle glitch is rejected
      inA[0] = 1'b1;
      waitA(0, 1'b1, 40, n, r, f);
      cycles(2);
      #1 base = fall0Cnt;
      inA[0] = 1'b0;
      cycles(15);
      inA[0] = 1'b1;
      cycles(30);
      #1 check("glitchNoFall", fall0Cnt - base, 0);
      check("glitchOut", outA[0], 1'b1);
      // opposite steps on channels 0 and 3 in the same cycle
      inA[3] = 1'b0;
      waitA(3, 1'b0, 40, n, r, f);
      check("simSetup", n, 18);
      cycles(2);
      inA[0] = 1'b0;
      inA[3] = 1'b1;
      waitA(0, 1'b0, 40, n, r, f);
      check("simEdge", n, 18);
      check("simFall", f, 4'b0001);
      check("simRise", r, 4'b1000);
      // reset while channel 1 is counting
      inA[1] = 1'b0;
      cycles(10);
      #1 base = strobeCnt;
      resetN = 1'b0;
      #1;
      check("midRstOut", outA, 4'hF);
      check("midRstStrobe", {riseA, fallA}, 8'h00);
      inA = 4'hF;
      cycles(3);
      resetN = 1'b1;
      cycles(30);
      #1 check("midRstNoStrobe", strobeCnt - base, 0);
      check("midRstOutAfter", outA, 4'hF);
      // prescaled channel: 25..32 cycles from s change (edge 2) to out change
      @(negedge clk);
      inB = 1'b0;
      waitB(1'b0, 60, n, fb);
      check("prescWin", (n - 2 >= 25 && n - 2 <= 32), 1);
      check("prescFall", fb, 1'b1);
      inB = 1'b1;
      waitB(1'b1, 60, n, fb);
      check("prescRiseWin", (n - 2 >= 25 && n - 2 <= 32), 1);
      cycles(2);
      #1 base = fallBCnt;
      inB = 1'b0;
      cycles(20);
      inB = 1'b1;
      cycles(3);
      inB = 1'b0;
      waitB(1'b0, 60, n, fb);
      check("prescBounceWin", (n - 2 >= 25 && n - 2 <= 32), 1);
      cycles(2);
      #1 check("prescBounceOneFall", fallBCnt - base, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
